addsub_pipe_r1: RTL and testbench

Parametrised, pipelined integer add/subtract unit with C/Z/V/S flags, carry-in modes and a valid/ready handshake. It replaces the single-cycle combinational subtractor in the execute stage, where full-width carry chains limit clock frequency. The carry chain is split into CHUNK_WIDTH slices, one slice per pipeline stage. Throughput is one operation per cycle.

---
 rtl/addsub_pipe_r1.sv | 237 +++++++++++++++++++++++
 tb/tb_addsub_pipe_r1.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe_r1.sv
// ---------------------------------------------------------------------------
// addsub_pipe_r1
//
// Pipelined integer add/subtract unit with carry/borrow, zero, overflow and
// sign flags. The DATA_WIDTH carry chain is cut into CHUNK_WIDTH slices and
// one slice is resolved per pipeline stage, so the longest combinational
// path is a single CHUNK_WIDTH adder instead of the full-width chain.
//
// Every operation is evaluated as A + B' + k:
//   op 00 ADD : B' =  B, k = 0
//   op 01 SUB : B' = ~B, k = 1
//   op 10 ADC : B' =  B, k = cin
//   op 11 SBB : B' = ~B, k = ~cin
// so op[0] selects inversion and op[1] selects the external carry-in.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operation on op/input1/input2/cin is valid
//   in_ready   : unit accepts an operation this cycle
//   op         : 00 ADD, 01 SUB, 10 ADC, 11 SBB
//   input1     : operand A
//   input2     : operand B
//   cin        : carry/borrow in (ADC/SBB only)
//   out_valid  : dataOut and the flags hold a result
//   out_ready  : downstream accepts the result
//   dataOut    : result, modulo 2^DATA_WIDTH
//   C          : carry out (ADD/ADC) or borrow (SUB/SBB)
//   Z          : result is zero
//   V          : signed overflow
//   S          : result sign bit
//
// Handshake: an operation is accepted on a rising edge where
// in_valid & in_ready; a result is consumed on a rising edge where
// out_valid & out_ready. in_ready = ~(out_valid & ~out_ready) and never
// looks at in_valid. While the output holds an unconsumed result the whole
// pipeline freezes (no bubble squeezing), so results leave strictly in
// acceptance order and the output is stable until taken.
//
// Latency is NUM_CHUNKS + 1 edges from acceptance: the accept edge loads
// stage 0, each following edge resolves one chunk, and the edge that
// resolves the last chunk loads the output register.
// ---------------------------------------------------------------------------
module addsub_pipe_r1 #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8,
    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] input1,
    input  logic [DATA_WIDTH-1:0] input2,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  C,
    output logic                  Z,
    output logic                  V,
    output logic                  S
);

    localparam int LAST = NUM_CHUNKS - 1;

    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
        $error("addsub_pipe_r1: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    // -----------------------------------------------------------------------
    // Global stall: the output holds a result nobody has taken yet.
    // -----------------------------------------------------------------------
    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // -----------------------------------------------------------------------
    // Operand conditioning at entry.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] b_entry;
    logic                  k_entry;

    assign b_entry = op[0] ? ~input2 : input2;
    // ADD 0, SUB 1, ADC cin, SBB ~cin
    assign k_entry = op[1] ? (cin ^ op[0]) : op[0];

    // -----------------------------------------------------------------------
    // Chunk stages. Stage k holds an operation whose chunks 0..k-1 are done.
    //
    // ar_q is a right-shifting register: its low CHUNK_WIDTH bits are the
    // next A chunk to add, and each finished sum chunk is shifted in at the
    // top. After NUM_CHUNKS shifts it holds the complete result in place.
    //
    // b_q only keeps the B' chunks not yet consumed, so it narrows by one
    // chunk per stage.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_st
        localparam int BW = DATA_WIDTH - k * CHUNK_WIDTH;

        logic                  vld_q;
        logic                  cy_q;    // carry into this chunk
        logic                  zero_q;  // all earlier chunks were zero
        logic                  sub_q;   // SUB/SBB: flags use borrow rules
        logic                  sa_q;    // sign of A
        logic                  sb_q;    // sign of B (uninverted)
        logic [DATA_WIDTH-1:0] ar_q;
        logic [BW-1:0]         b_q;

        logic [CHUNK_WIDTH:0]  sum;
        logic [DATA_WIDTH-1:0] ar_n;
        logic                  zero_n;

        assign sum = {1'b0, ar_q[CHUNK_WIDTH-1:0]}
                   + {1'b0, b_q[CHUNK_WIDTH-1:0]}
                   + {{CHUNK_WIDTH{1'b0}}, cy_q};

        if (NUM_CHUNKS == 1) begin : g_single
            assign ar_n = sum[CHUNK_WIDTH-1:0];
        end else begin : g_multi
            assign ar_n = {sum[CHUNK_WIDTH-1:0], ar_q[DATA_WIDTH-1:CHUNK_WIDTH]};
        end

        assign zero_n = zero_q & (sum[CHUNK_WIDTH-1:0] == '0);

        if (k == 0) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= 1'b0;
                    cy_q   <= 1'b0;
                    zero_q <= 1'b0;
                    sub_q  <= 1'b0;
                    sa_q   <= 1'b0;
                    sb_q   <= 1'b0;
                    ar_q   <= '0;
                    b_q    <= '0;
                end else if (!stall) begin
                    // in_ready is 1 here, so in_valid alone marks an accept.
                    vld_q  <= in_valid;
                    cy_q   <= k_entry;
                    zero_q <= 1'b1;
                    sub_q  <= op[0];
                    sa_q   <= input1[DATA_WIDTH-1];
                    sb_q   <= input2[DATA_WIDTH-1];
                    ar_q   <= input1;
                    b_q    <= b_entry;
                end
            end
        end else begin : g_link
            localparam int PBW = DATA_WIDTH - (k - 1) * CHUNK_WIDTH;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= 1'b0;
                    cy_q   <= 1'b0;
                    zero_q <= 1'b0;
                    sub_q  <= 1'b0;
                    sa_q   <= 1'b0;
                    sb_q   <= 1'b0;
                    ar_q   <= '0;
                    b_q    <= '0;
                end else if (!stall) begin
                    vld_q  <= g_st[k-1].vld_q;
                    cy_q   <= g_st[k-1].sum[CHUNK_WIDTH];
                    zero_q <= g_st[k-1].zero_n;
                    sub_q  <= g_st[k-1].sub_q;
                    sa_q   <= g_st[k-1].sa_q;
                    sb_q   <= g_st[k-1].sb_q;
                    ar_q   <= g_st[k-1].ar_n;
                    b_q    <= g_st[k-1].b_q[PBW-1:CHUNK_WIDTH];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Flag finalisation from the last stage.
    // -----------------------------------------------------------------------
    logic                  last_vld;
    logic                  last_sub;
    logic                  last_sa;
    logic                  last_sb;
    logic [DATA_WIDTH-1:0] fin_data;
    logic                  fin_c;
    logic                  fin_z;
    logic                  fin_v;
    logic                  fin_s;

    assign last_vld = g_st[LAST].vld_q;
    assign last_sub = g_st[LAST].sub_q;
    assign last_sa  = g_st[LAST].sa_q;
    assign last_sb  = g_st[LAST].sb_q;
    assign fin_data = g_st[LAST].ar_n;
    assign fin_s    = fin_data[DATA_WIDTH-1];
    assign fin_z    = g_st[LAST].zero_n;

    // For subtraction the chain computes A + ~B + k, so a missing carry out
    // means a borrow occurred.
    assign fin_c = last_sub ^ g_st[LAST].sum[CHUNK_WIDTH];

    // Overflow in terms of the original (uninverted) B sign.
    always_comb begin
        fin_v = 1'b0;
        if (last_sub) begin
            fin_v = (last_sa != last_sb) && (fin_s == last_sb);
        end else begin
            fin_v = (last_sa == last_sb) && (fin_s != last_sa);
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs. Data/flags only move when a new result arrives, so
    // they also keep the last result after out_valid drops.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dataOut   <= '0;
            C         <= 1'b0;
            Z         <= 1'b0;
            V         <= 1'b0;
            S         <= 1'b0;
        end else if (!stall) begin
            out_valid <= last_vld;
            if (last_vld) begin
                dataOut <= fin_data;
                C       <= fin_c;
                Z       <= fin_z;
                V       <= fin_v;
                S       <= fin_s;
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe_r1.sv
// ---------------------------------------------------------------------------
// tb_addsub_pipe_r1
//
// Bench for addsub_pipe_r1. Two instances: the default 4-chunk pipeline and
// a single-chunk (CHUNK_WIDTH = DATA_WIDTH) variant. Results of the main
// instance are predicted by an arithmetic reference model on acceptance and
// compared in order on consumption.
// ---------------------------------------------------------------------------
module tb_addsub_pipe_r1;

    localparam int W = 32;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ---------------- main DUT (4 chunks) ----------------
    logic         in_valid, in_ready, out_valid, out_ready, cin;
    logic [1:0]   op;
    logic [W-1:0] input1, input2, data_out;
    logic         c_f, z_f, v_f, s_f;

    addsub_pipe_r1 #(.DATA_WIDTH(W), .CHUNK_WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .input1    (input1),
        .input2    (input2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataOut   (data_out),
        .C         (c_f),
        .Z         (z_f),
        .V         (v_f),
        .S         (s_f)
    );

    // ---------------- single-chunk DUT ----------------
    logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_cin;
    logic [1:0]   w_op;
    logic [W-1:0] w_input1, w_input2, w_data_out;
    logic         w_c_f, w_z_f, w_v_f, w_s_f;

    addsub_pipe_r1 #(.DATA_WIDTH(W), .CHUNK_WIDTH(W)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .op        (w_op),
        .input1    (w_input1),
        .input2    (w_input2),
        .cin       (w_cin),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .dataOut   (w_data_out),
        .C         (w_c_f),
        .Z         (w_z_f),
        .V         (w_v_f),
        .S         (w_s_f)
    );

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [35:0]  exp_q[$];   // {data, C, Z, V, S}
    logic [W-1:0] recv_q[$];
    logic         rnd_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: true unsigned/signed arithmetic on the operands.
    function automatic logic [35:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic ci);
        logic        is_sub;
        longint      ce;
        logic [W:0]  wide;
        logic [W-1:0] r;
        logic        carry;
        longint      sr;
        logic        ovf;
        is_sub = (o == OP_SUB) || (o == OP_SBB);
        ce     = ((o == OP_ADC) || (o == OP_SBB)) && ci ? 1 : 0;
        if (!is_sub) begin
            wide  = {1'b0, a} + {1'b0, b} + 33'(ce);
            r     = wide[W-1:0];
            carry = wide[W];
            sr    = longint'($signed(a)) + longint'($signed(b)) + ce;
        end else begin
            r     = a - b - 32'(ce);
            carry = ({1'b0, a} < ({1'b0, b} + 33'(ce)));
            sr    = longint'($signed(a)) - longint'($signed(b)) - ce;
        end
        ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {r, carry, (r == '0), ovf, r[W-1]};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Monitor: consume before predict, both decided by values stable
    // half a cycle ahead of the edge on which they take effect.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    chk("result", {data_out, c_f, z_f, v_f, s_f}, exp_q.pop_front());
                    recv_q.push_back(data_out);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, input1, input2, cin));
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        op       = o;
        input1   = a;
        input2   = b;
        cin      = c;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", acc, 1'b1);
    endtask

    task automatic run_one(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, output int lat);
        in_valid = 1'b1;
        op       = o;
        input1   = a;
        input2   = b;
        cin      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic directed(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic c,
                            input logic [W-1:0] ed, input logic [3:0] ef);
        int lat;
        run_one(o, a, b, c, lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_data"}, data_out, ed);
        chk({tag, "_flags"}, {c_f, z_f, v_f, s_f}, ef);
    endtask

    task automatic w_directed(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic c,
                              input logic [W-1:0] ed, input logic [3:0] ef);
        int lat;
        w_in_valid = 1'b1;
        w_op       = o;
        w_input1   = a;
        w_input2   = b;
        w_cin      = c;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!w_out_valid && lat < 20);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_data"}, w_data_out, ed);
        chk({tag, "_flags"}, {w_c_f, w_z_f, w_v_f, w_s_f}, ef);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        op          = OP_ADD;
        input1      = '0;
        input2      = '0;
        cin         = 1'b0;
        out_ready   = 1'b1;
        w_in_valid  = 1'b0;
        w_op        = OP_ADD;
        w_input1    = '0;
        w_input2    = '0;
        w_cin       = 1'b0;
        w_out_ready = 1'b1;
        rnd_acc     = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_data", data_out, 32'h0);
        chk("rst_flags", {c_f, z_f, v_f, s_f}, 4'b0000);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_w_out_valid", w_out_valid, 1'b0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases, flags ordered {C,Z,V,S}
        directed("sub_5_3",   OP_SUB, 32'd5,          32'd3, 1'b0, 32'h0000_0002, 4'b0000);
        directed("sub_3_5",   OP_SUB, 32'd3,          32'd5, 1'b0, 32'hFFFF_FFFE, 4'b1001);
        directed("sub_min_1", OP_SUB, 32'h8000_0000,  32'd1, 1'b0, 32'h7FFF_FFFF, 4'b0010);
        directed("add_wrap",  OP_ADD, 32'hFFFF_FFFF,  32'd1, 1'b0, 32'h0000_0000, 4'b1100);
        directed("adc_ovf",   OP_ADC, 32'h7FFF_FFFF,  32'd0, 1'b1, 32'h8000_0000, 4'b0011);
        directed("sbb_0_0",   OP_SBB, 32'd0,          32'd0, 1'b1, 32'hFFFF_FFFF, 4'b1001);

        // Single-chunk variant
        w_directed("w_sub_5_3",   OP_SUB, 32'd5,         32'd3, 1'b0, 32'h0000_0002, 4'b0000);
        w_directed("w_sub_min_1", OP_SUB, 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 4'b0010);

        // Back-to-back stream with a 3-cycle downstream stall
        recv_q.delete();
        fork
            begin
                for (int i = 1; i <= 8; i++) send(OP_ADD, W'(i), W'(i), 1'b0);
            end
            begin
                int seen;
                int g;
                seen = 0;
                g    = 0;
                while (seen < 2 && g < 40) begin
                    @(posedge clk);
                    #1;
                    g++;
                    if (out_valid) seen++;
                end
                chk("pre_stall_in_ready", in_ready, 1'b1);
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk("stall_in_ready", in_ready, 1'b0);
                    chk("stall_data", data_out, 32'd4);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
                #1;
                chk("stall_release_in_ready", in_ready, 1'b1);
            end
        join
        for (int g = 0; g < 40 && exp_q.size() != 0; g++) begin
            @(posedge clk);
            #1;
        end
        chk("stream_drain", exp_q.size(), 0);
        chk("stream_count", recv_q.size(), 8);
        for (int i = 0; i < recv_q.size(); i++) chk("stream_order", recv_q[i], 2 * (i + 1));

        // Asynchronous reset with three operations in flight
        send(OP_SUB, 32'd100, 32'd1, 1'b0);
        send(OP_ADD, 32'd7,   32'd9, 1'b0);
        send(OP_SUB, 32'd50,  32'd8, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_data", data_out, 32'h0);
        chk("midrst_flags", {c_f, z_f, v_f, s_f}, 4'b0000);
        chk("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("post_rst_sub_10_10", OP_SUB, 32'd10, 32'd10, 1'b0, 32'h0, 4'b0100);

        // Randomised traffic with random back-pressure
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in_valid || rnd_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                op       = 2'($urandom_range(0, 3));
                input1   = rnd_operand();
                input2   = rnd_operand();
                cin      = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rnd_acc = in_valid & in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 60 && exp_q.size() != 0; g++) begin
            @(posedge clk);
            #1;
        end
        chk("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
